// File: rtl/wash_pkg.sv
// Shared encodings, phase timing constants and the action-to-drive decode
// for the washing-machine program scheduler.
package wash_pkg;

  localparam int SEC_W = 6;  // phase-second counter, covers 0..39
  localparam int REM_W = 7;  // program seconds remaining, covers 0..80

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'b00,
    PH_WASH  = 2'b01,
    PH_RINSE = 2'b10,
    PH_SPIN  = 2'b11
  } phase_t;

  typedef enum logic [2:0] {
    ACT_IDLE     = 3'd0,
    ACT_ROTATE   = 3'd1,
    ACT_STEW     = 3'd2,
    ACT_ADDWATER = 3'd3,
    ACT_DRAIN    = 3'd4,
    ACT_FSPIN    = 3'd5,
    ACT_RSPIN    = 3'd6
  } action_t;

  localparam logic [SEC_W-1:0] WASH_S_DUR = 6'd20;
  localparam logic [SEC_W-1:0] WASH_M_DUR = 6'd30;
  localparam logic [SEC_W-1:0] WASH_L_DUR = 6'd40;
  localparam logic [SEC_W-1:0] RINSE_DUR  = 6'd20;
  localparam logic [SEC_W-1:0] SPIN_DUR   = 6'd20;
  localparam logic [SEC_W-1:0] FILL_DUR   = 6'd4;
  localparam logic [SEC_W-1:0] DRAIN_DUR  = 6'd4;

  typedef struct packed {
    logic motor_fwd;
    logic motor_rev;
    logic motor_fast;
    logic valve_in;
    logic valve_out;
  } drive_t;

  // Motor/valve lines for one action; forward and reverse are exclusive.
  function automatic drive_t action_drive(input action_t act);
    drive_t d;
    d = '0;
    case (act)
      ACT_ROTATE:   d.motor_fwd = 1'b1;
      ACT_FSPIN:    begin d.motor_fwd = 1'b1; d.motor_fast = 1'b1; end
      ACT_RSPIN:    begin d.motor_rev = 1'b1; d.motor_fast = 1'b1; end
      ACT_ADDWATER: d.valve_in  = 1'b1;
      ACT_DRAIN:    d.valve_out = 1'b1;
      default:      d = '0;
    endcase
    return d;
  endfunction

  // Wash phase length for the selected load size.
  function automatic logic [SEC_W-1:0] wash_duration(input logic [1:0] mode);
    case (mode)
      2'b10:   return WASH_M_DUR;
      2'b11:   return WASH_L_DUR;
      default: return WASH_S_DUR;
    endcase
  endfunction

  // Whole-program length; spin-only skips wash and rinse.
  function automatic logic [REM_W-1:0] total_duration(input logic [1:0] mode);
    if (mode == 2'b00)
      return REM_W'(SPIN_DUR);
    return REM_W'(wash_duration(mode)) + REM_W'(RINSE_DUR) + REM_W'(SPIN_DUR);
  endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// 1 s time base: counts enabled cycles and pulses o_tick on the last count
// of each TICK_DIV-cycle period. i_clr restarts the period; with i_en low
// the count holds so a paused program resumes mid-second.
module wash_tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && !i_clr && (r_cnt == LAST);

  // Prescaler count: clear wins, otherwise advance and wrap while enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/wash_sched.sv
// Washing-machine program scheduler: latches the mode on start, walks
// wash -> rinse -> spin one second at a time and decodes the per-second
// action onto motor and valve lines.
// Optional build macro: WASH_DOOR_INTERLOCK_EN (door switch gates start,
// an open door pauses a running program).
module wash_sched
  import wash_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic [1:0]       i_mode,
  input  logic             i_door_closed,
  output logic [1:0]       o_phase,
  output logic [2:0]       o_action,
  output logic             o_motor_fwd,
  output logic             o_motor_rev,
  output logic             o_motor_fast,
  output logic             o_valve_in,
  output logic             o_valve_out,
  output logic [REM_W-1:0] o_remain_s,
  output logic             o_busy,
  output logic             o_done
);

  state_t           r_state, w_state_nxt;
  phase_t           r_phase, w_phase_nxt;
  logic [SEC_W-1:0] r_sec, w_sec_nxt;
  logic [REM_W-1:0] r_remain, w_remain_nxt;
  logic [SEC_W-1:0] r_wash_dur, w_wash_dur_nxt;

  logic             w_door_ok;
  logic             w_hold;
  logic             w_start_ok;
  logic             w_run;
  logic             w_clr;
  logic             w_tick;
  logic [SEC_W-1:0] w_dur;
  action_t          w_action;
  drive_t           w_drive;

`ifdef WASH_DOOR_INTERLOCK_EN
  assign w_door_ok = i_door_closed;
`else
  logic w_unused_door;
  assign w_unused_door = i_door_closed;
  assign w_door_ok     = 1'b1;
`endif

  assign w_hold     = i_pause || !w_door_ok;
  assign w_start_ok = i_start && w_door_ok;
  assign w_run      = (r_state == ST_RUN);

  wash_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_run),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // Length of the phase currently being executed.
  always_comb begin
    w_dur = SPIN_DUR;
    case (r_phase)
      PH_WASH:  w_dur = r_wash_dur;
      PH_RINSE: w_dur = RINSE_DUR;
      default:  w_dur = SPIN_DUR;
    endcase
  end

  // Program state register and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_IDLE;
      r_sec      <= '0;
      r_remain   <= '0;
      r_wash_dur <= WASH_S_DUR;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_sec      <= w_sec_nxt;
      r_remain   <= w_remain_nxt;
      r_wash_dur <= w_wash_dur_nxt;
    end
  end

  // Next state: start/resume decisions, per-second advance, phase rollover.
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_sec_nxt      = r_sec;
    w_remain_nxt   = r_remain;
    w_wash_dur_nxt = r_wash_dur;
    w_clr          = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_ok) begin
          w_clr          = 1'b1;
          w_state_nxt    = ST_RUN;
          w_sec_nxt      = '0;
          w_wash_dur_nxt = wash_duration(i_mode);
          w_remain_nxt   = total_duration(i_mode);
          w_phase_nxt    = (i_mode == 2'b00) ? PH_SPIN : PH_WASH;
        end
      end
      ST_RUN: begin
        if (w_tick) begin
          if (r_remain != '0)
            w_remain_nxt = r_remain - 1'b1;
          if (r_sec == w_dur - 1'b1) begin
            w_sec_nxt = '0;
            case (r_phase)
              PH_WASH:  w_phase_nxt = PH_RINSE;
              PH_RINSE: w_phase_nxt = PH_SPIN;
              default: begin
                w_phase_nxt  = PH_IDLE;
                w_state_nxt  = ST_DONE;
                w_remain_nxt = '0;
              end
            endcase
          end else begin
            w_sec_nxt = r_sec + 1'b1;
          end
        end
        // The tick's advance always lands; a finishing tick beats pause.
        if (w_hold && (w_state_nxt != ST_DONE))
          w_state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (!w_hold)
          w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-second action. Bit 1 of (sec - 4) equals bit 1 of sec, so the
  // rotate/stew and forward/reverse alternation reads r_sec[1] directly.
  always_comb begin
    w_action = ACT_IDLE;
    if (w_run) begin
      case (r_phase)
        PH_WASH: begin
          if (r_sec < FILL_DUR)
            w_action = ACT_ADDWATER;
          else if (r_sec >= r_wash_dur - DRAIN_DUR)
            w_action = ACT_DRAIN;
          else
            w_action = r_sec[1] ? ACT_STEW : ACT_ROTATE;
        end
        PH_RINSE: begin
          if (r_sec < FILL_DUR)
            w_action = ACT_ADDWATER;
          else if (r_sec >= RINSE_DUR - DRAIN_DUR)
            w_action = ACT_DRAIN;
          else
            w_action = r_sec[1] ? ACT_RSPIN : ACT_FSPIN;
        end
        PH_SPIN: begin
          w_action = (r_sec < DRAIN_DUR) ? ACT_DRAIN : ACT_FSPIN;
        end
        default: w_action = ACT_IDLE;
      endcase
    end
  end

  assign w_drive      = action_drive(w_action);
  assign o_phase      = r_phase;
  assign o_action     = w_action;
  assign o_motor_fwd  = w_drive.motor_fwd;
  assign o_motor_rev  = w_drive.motor_rev;
  assign o_motor_fast = w_drive.motor_fast;
  assign o_valve_in   = w_drive.valve_in;
  // The drain valve stays open for the whole spin phase.
  assign o_valve_out  = w_drive.valve_out || (w_run && (r_phase == PH_SPIN));
  assign o_remain_s   = r_remain;
  assign o_busy       = (r_state == ST_RUN) || (r_state == ST_PAUSED);
  assign o_done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_wash_sched.sv
// Self-checking bench for wash_sched with TICK_DIV = 4. A program-time
// reference model (elapsed run cycles -> seconds -> phase/sec/action)
// predicts every output each cycle; directed steps cover the test plan
// and a randomized section drives pause, door, start and mode noise.
module tb_wash_sched;

  localparam int TICK_DIV = 4;
`ifdef WASH_DOOR_INTERLOCK_EN
  localparam bit DOOR_EN = 1'b1;
`else
  localparam bit DOOR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       door = 1'b1;

  logic [1:0] o_phase;
  logic [2:0] o_action;
  logic       o_motor_fwd, o_motor_rev, o_motor_fast, o_valve_in, o_valve_out;
  logic [6:0] o_remain_s;
  logic       o_busy, o_done;

  wash_sched #(.TICK_DIV(TICK_DIV)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (start),
    .i_pause       (pause),
    .i_mode        (mode),
    .i_door_closed (door),
    .o_phase       (o_phase),
    .o_action      (o_action),
    .o_motor_fwd   (o_motor_fwd),
    .o_motor_rev   (o_motor_rev),
    .o_motor_fast  (o_motor_fast),
    .o_valve_in    (o_valve_in),
    .o_valve_out   (o_valve_out),
    .o_remain_s    (o_remain_s),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  // Reference model: 0 idle, 1 active (running or paused), 2 done.
  int m_st = 0;
  bit m_paused = 1'b0;
  int m_mode = 0;
  int m_cyc = 0;  // cycles spent running since the accepted start

  function automatic int wash_len(int md);
    return 10 + 10 * md;  // 20 / 30 / 40 s
  endfunction

  function automatic int total_len(int md);
    return (md == 0) ? 20 : wash_len(md) + 40;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_paused = 1'b0; m_mode = 0; m_cyc = 0;
  endfunction

  // Apply one clock edge's worth of program rules to the model.
  function automatic void model_edge(bit r, bit st, bit pz, bit dr, int md);
    bit hold;
    bit door_ok;
    hold    = pz || (DOOR_EN && !dr);
    door_ok = !DOOR_EN || dr;
    if (!r) begin
      model_reset();
    end else if (m_st != 1) begin
      if (st && door_ok) begin
        m_st = 1; m_paused = 1'b0; m_mode = md; m_cyc = 0;
      end
    end else if (m_paused) begin
      if (!hold) m_paused = 1'b0;
    end else begin
      m_cyc++;
      if (m_cyc == total_len(m_mode) * TICK_DIV) m_st = 2;
      else if (hold) m_paused = 1'b1;
    end
  endfunction

  function automatic int exp_action(int ph, int s, int w);
    if (ph == 1) begin
      if (s < 4) return 3;
      if (s >= w - 4) return 4;
      return (((s - 4) >> 1) & 1) ? 2 : 1;
    end
    if (ph == 2) begin
      if (s < 4) return 3;
      if (s >= 16) return 4;
      return (((s - 4) >> 1) & 1) ? 6 : 5;
    end
    return (s < 4) ? 4 : 5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output with the model's prediction.
  task automatic check_all();
    int e, ph, s, act, w;
    int x_ph, x_act, x_rem, x_busy, x_done, x_fwd, x_rev, x_fast, x_vin, x_vout;
    x_ph = 0; x_act = 0; x_rem = 0; x_busy = 0; x_done = 0;
    x_fwd = 0; x_rev = 0; x_fast = 0; x_vin = 0; x_vout = 0;
    if (m_st == 2) begin
      x_done = 1;
    end else if (m_st == 1) begin
      e = m_cyc / TICK_DIV;
      w = wash_len(m_mode);
      if (m_mode == 0)      begin ph = 3; s = e; end
      else if (e < w)       begin ph = 1; s = e; end
      else if (e < w + 20)  begin ph = 2; s = e - w; end
      else                  begin ph = 3; s = e - w - 20; end
      x_ph = ph; x_busy = 1; x_rem = total_len(m_mode) - e;
      if (!m_paused) begin
        act    = exp_action(ph, s, w);
        x_act  = act;
        x_fwd  = (act == 1 || act == 5) ? 1 : 0;
        x_rev  = (act == 6) ? 1 : 0;
        x_fast = (act == 5 || act == 6) ? 1 : 0;
        x_vin  = (act == 3) ? 1 : 0;
        x_vout = (act == 4 || ph == 3) ? 1 : 0;
      end
    end
    chk("phase", o_phase, x_ph);
    chk("action", o_action, x_act);
    chk("remain_s", o_remain_s, x_rem);
    chk("busy", o_busy, x_busy);
    chk("done", o_done, x_done);
    chk("motor_fwd", o_motor_fwd, x_fwd);
    chk("motor_rev", o_motor_rev, x_rev);
    chk("motor_fast", o_motor_fast, x_fast);
    chk("valve_in", o_valve_in, x_vin);
    chk("valve_out", o_valve_out, x_vout);
    chk("fwd_rev_exclusive", o_motor_fwd & o_motor_rev, 0);
  endtask

  task automatic step();
    @(posedge clk);
    n_cyc++;
    model_edge(rst, start, pause, door, int'(mode));
    #1;
    check_all();
  endtask

  task automatic pulse_start(input logic [1:0] md);
    mode = md; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Advance until the model has reached elapsed second e (bounded).
  task automatic run_to(input int e);
    int guard;
    guard = 0;
    while (m_cyc < e * TICK_DIV && guard < 5000) begin
      step();
      guard++;
    end
    chk("run_to_bound", (guard < 5000) ? 1 : 0, 1);
  endtask

  task automatic run_until_done(input string tag, output int at_cyc);
    int guard;
    guard = 0;
    while (o_done !== 1'b1 && guard < 3000) begin
      step();
      guard++;
    end
    chk(tag, o_done, 1);
    at_cyc = n_cyc;
  endtask

  initial begin
    int t0, t1;

    // Reset state
    #2 rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    step();

    // Small program, full run, with ignored second start and mode change
    pulse_start(2'b01);
    t0 = n_cyc;
    chk("t1_phase", o_phase, 1);
    chk("t1_action", o_action, 3);
    chk("t1_valve_in", o_valve_in, 1);
    chk("t1_remain", o_remain_s, 60);
    run_to(4);
    chk("t1_rotate", o_action, 1);
    mode = 2'b11;
    pulse_start(2'b11);
    run_to(16);
    chk("t1_drain", o_action, 4);
    chk("t1_remain16", o_remain_s, 44);
    run_to(20);
    chk("t1_rinse", o_phase, 2);
    run_to(40);
    chk("t1_spin", o_phase, 3);
    run_until_done("t1_done_reached", t1);
    chk("t1_done_time", t1 - t0, 60 * TICK_DIV);
    chk("t1_done_phase", o_phase, 0);
    chk("t1_done_remain", o_remain_s, 0);
    step();

    // Spin-only
    pulse_start(2'b00);
    t0 = n_cyc;
    chk("t2_phase", o_phase, 3);
    chk("t2_remain", o_remain_s, 20);
    chk("t2_drain", o_action, 4);
    chk("t2_valve_out", o_valve_out, 1);
    run_to(4);
    chk("t2_fspin", o_action, 5);
    chk("t2_fast", o_motor_fast, 1);
    run_until_done("t2_done_reached", t1);
    chk("t2_done_time", t1 - t0, 20 * TICK_DIV);

    // Pause for 50 cycles at wash sec 10 (medium program)
    pulse_start(2'b10);
    t0 = n_cyc;
    run_to(10);
    pause = 1'b1;
    repeat (50) step();
    chk("t3_paused_remain", o_remain_s, 60);
    chk("t3_paused_action", o_action, 0);
    chk("t3_paused_phase", o_phase, 1);
    chk("t3_paused_motor", o_motor_fwd | o_motor_rev | o_motor_fast, 0);
    chk("t3_paused_valves", o_valve_in | o_valve_out, 0);
    pause = 1'b0;
    run_until_done("t3_done_reached", t1);
    chk("t3_done_time", t1 - t0, 70 * TICK_DIV + 50);

`ifdef WASH_DOOR_INTERLOCK_EN
    // Door interlock
    door = 1'b0;
    pulse_start(2'b01);
    chk("t4_refused_busy", o_busy, 0);
    chk("t4_refused_done", o_done, 1);
    door = 1'b1;
    pulse_start(2'b01);
    run_to(26);
    door = 1'b0;
    repeat (10) step();
    chk("t4_door_paused_action", o_action, 0);
    chk("t4_door_paused_remain", o_remain_s, 34);
    door = 1'b1;
    step();
    chk("t4_resume_rspin", o_action, 6);
    run_until_done("t4_done_reached", t1);
`endif

    // Randomized programs with pause/door/start/mode noise
    for (int r = 0; r < 6; r++) begin
      int guard;
      pulse_start(2'($urandom_range(0, 3)));
      guard = 0;
      while (m_st != 2 && guard < 2500) begin
        pause = ($urandom_range(0, 7) == 0);
        door  = ($urandom_range(0, 15) != 0);
        start = ($urandom_range(0, 31) == 0);
        mode  = 2'($urandom_range(0, 3));
        step();
        guard++;
      end
      pause = 1'b0; door = 1'b1; start = 1'b0;
      chk("rand_done_reached", o_done, 1);
    end

    // Reset mid-run during spin FSPIN
    pulse_start(2'b00);
    run_to(5);
    chk("t6_pre_fspin", o_action, 5);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_async_fwd", o_motor_fwd, 0);
    chk("t6_async_vout", o_valve_out, 0);
    repeat (2) step();
    rst = 1'b1;
    step();
    pulse_start(2'b01);
    chk("t6_restart_phase", o_phase, 1);
    run_to(5);
    chk("t6_restart_rotate", o_action, 1);
    run_until_done("t6_done_reached", t1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wash_sched.md
# wash_sched

Program scheduler for the washing-machine controller. It latches the wash mode at start and sequences the phases (wash, rinse, spin) and the per-second actions inside each phase. It drives the motor and valve command lines and reports phase, action and remaining seconds to the display and status-light logic. It owns the 1 s time base and handles pause and door events.

## Interface
- TICK_DIV, 100000000, clk cycles per 1 s tick (minimum 2)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle start request
- pause  in  1  level; high freezes the program
- mode  in  2  00 spin-only, 01 small, 10 medium, 11 large
- door_closed  in  1  door switch, 1 = closed
- phase  out  2  00 idle/setup, 01 wash, 10 rinse, 11 spin
- action  out  3  0 IDLE, 1 ROTATE, 2 STEW, 3 ADDWATER, 4 DRAIN, 5 FSPIN, 6 RSPIN
- motor_fwd, motor_rev, motor_fast  out  1 each  motor commands
- valve_in, valve_out  out  1 each  fill and drain valves
- remain_s  out  7  program seconds remaining (0..80)
- busy  out  1  program running or paused
- done  out  1  program complete; held until the next accepted start

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset → IDLE with every output 0 and action IDLE.
- Start is accepted only in IDLE or DONE, and only with the door closed. An accepted start:
  - latches mode and clears the prescaler and the phase-second counter `sec`;
  - loads `remain_s` with the total time;
  - enters RUN in phase 11 if mode is 00, otherwise in phase 01.
- Start is ignored in RUN and PAUSED. A mode change after start is ignored.
- Phase durations: wash W = 20, 30 or 40 s for mode 01, 10 or 11. Rinse 20 s. Spin 20 s.
- Totals: mode 00 = 20 s, 01 = 60 s, 10 = 70 s, 11 = 80 s.
- Wash actions by `sec`:
  - s < 4: ADDWATER;
  - s ≥ W−4: DRAIN;
  - otherwise ROTATE when bit 1 of (s−4) is 0, STEW when it is 1.
- Rinse actions: s < 4 ADDWATER; 4..15 FSPIN when bit 1 of (s−4) is 0, RSPIN when it is 1; 16..19 DRAIN.
- Spin actions: s < 4 DRAIN; 4..19 FSPIN. valve_out = 1 for the whole spin phase.
- Output decode:

  | action | outputs high |
  |---|---|
  | ROTATE | motor_fwd |
  | FSPIN | motor_fwd, motor_fast |
  | RSPIN | motor_rev, motor_fast |
  | ADDWATER | valve_in |
  | DRAIN | valve_out |
  | STEW, IDLE | none |

  motor_fwd and motor_rev are never high together.
- On each tick in RUN:
  - `sec` and `remain_s` each change by one (`sec` up, `remain_s` down);
  - at sec = duration−1, move to the next phase (wash→rinse→spin) with `sec` = 0;
  - the tick that ends spin enters DONE: remain_s = 0, phase = 00, done = 1, busy = 0.
- Pause takes effect when pause = 1 or the door opens in RUN: go to PAUSED.
  - The prescaler, `sec` and `remain_s` freeze.
  - The motor and valve outputs are forced to 0; action reads IDLE.
  - phase holds its value.
- Resume when pause = 0 and the door is closed: return to RUN and continue from the frozen prescaler count.

## Timing
- All state is registered. Outputs decode from registered state only, with no input-to-output combinational path.
- An accepted start at edge N gives busy = 1 and the first action at edge N+1. The first tick comes TICK_DIV cycles after that.
- A tick and a pause condition in the same cycle: the tick's count and phase advance take effect, then PAUSED.
- A tick that ends the program and pause in the same cycle: DONE wins.
- Reset mid-operation: every output clears asynchronously, with no drain sequence.
- remain_s never wraps below 0. `sec` is wide enough for 0..39.

## Configuration
- `WASH_DOOR_INTERLOCK_EN` defined:
  - start is refused while door_closed = 0;
  - a door opening in RUN forces PAUSED;
  - resume requires the door closed.
- Undefined: door_closed is ignored and treated as 1. Pause comes from the pause input only.

## Structure
- Package wash_pkg holds:
  - phase and action encodings;
  - phase-duration constants: wash 20/30/40, rinse 20, spin 20, fill 4, drain 4;
  - the action-to-output decode function.
- Sub-module wash_tick_gen: TICK_DIV prescaler with enable (hold) and clear, emitting a one-cycle tick.
- wash_sched contains the FSM, the `sec` and `remain_s` counters, and the output decode.

## Test plan
Benches use TICK_DIV = 4.
- **Small program, full run:** mode 01, start.
  - Next cycle: phase 01, ADDWATER, valve_in = 1, remain_s = 60.
  - Wash sec 4: ROTATE. Wash sec 16: DRAIN.
  - After 20 ticks: rinse. After 40 ticks: spin.
  - After 60 ticks: done = 1, phase 00, remain_s = 0.
- **Spin-only:** mode 00 → phase 11, remain_s = 20, DRAIN with valve_out = 1. Sec 4: FSPIN, motor_fast = 1. Done after 20 ticks.
- **Pause:** hold pause for 50 cycles at wash sec 10.
  - remain_s and action frozen; motor and valve outputs 0.
  - After release the program resumes and completes at exactly total ticks plus the paused cycles.
- **Door interlock (macro defined):**
  - Start with the door open: ignored, stays IDLE.
  - Door opened at rinse sec 6: PAUSED. Door closed: resumes at rinse sec 6.
- **Ignored inputs:** a second start, and mode changed to 11 mid-run, leave remain_s and the phase sequence unaffected.
- **Reset mid-run:** rst low during spin FSPIN → all outputs 0 immediately. After release: IDLE, and a start works normally.
